id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
Instruction-decode stage feeding the ID/EX pipeline register. Holds the 32x32 register file and decodes RV32I instructions into the 9-bit control word. Generates the 64-bit sign-extended immediate, detects load-use hazards and inserts bubbles. Tracks end-of-program with a drain/halt state machine that respects the continuous and stepwise pipeline modes.

Parameters:
NB_INSTRUCT, 32, instruction and register data width
NB_PC, 6, program-counter width
NB_REG_ADDR, 5, register address width (32 registers)
DRAIN_CYCLES, 4, cycles after EOF before halting, covering EX/MEM/WB plus margin

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_instruction  in  32  instruction from IF/ID latch
i_PC  in  NB_PC  PC of the instruction
i_EOF_flag  in  1  end-of-program marker from IF/ID
i_pipeline_mode  in  2  01 continuous, 11 stepwise, other codes idle
i_execute_instruct  in  1  step strobe, used in stepwise mode only
i_wb_reg_write  in  1  write-back enable
i_wb_rd  in  5  write-back destination register
i_wb_data  in  32  write-back data
i_ex_mem_read  in  1  instruction in EX is a load
i_ex_rd  in  5  destination register of the instruction in EX
o_control_bits  out  9  [8]ALUSrc [7:6]ALUOp [5]Branch [4]MemRead [3]MemWrite [2]RegWrite [1]MemtoReg [0]Jump
o_PC  out  NB_PC  pass-through of i_PC
o_read_data1  out  32  rs1 value
o_read_data2  out  32  rs2 value
o_imm_gen  out  64  sign-extended immediate
o_instruct_30_14_12  out  4  {instr[30], instr[14:12]}
o_instruct_11_7  out  5  rd field
o_EOF_flag  out  1  EOF forwarded; forced 0 while stalled
o_stall  out  1  freeze PC and IF/ID
o_halted  out  1  pipeline drained after EOF

Behaviour:
- advance = (mode==01) | (mode==11 & i_execute_instruct). All state updates (register-file writes, FSM, counter) occur only on posedge clk with advance=1.
- Reset (async): all 32 registers clear to 0, FSM goes to RUN, counter clears to 0, o_halted=0. The decode outputs are combinational from the inputs.
- Register file:
  - Synchronous write when advance & i_wb_reg_write & i_wb_rd!=0.
  - x0 always reads 0.
  - Reads are combinational with write-through bypass: if i_wb_reg_write & i_wb_rd==rs & rs!=0, the read returns i_wb_data in the same cycle.
- Immediate by opcode, each sign-extended to 64 bits from its top bit:
  - I-type (0000011, 0010011, 1100111)
  - S-type (0100011)
  - B-type (1100011): {imm[12:1],0}
  - U-type (0110111, 0010111): {imm[31:12],12'b0}
  - J-type (1101111)
  - any other opcode: 0
- Control word by opcode:
  - R-type 0110011 = 0_10_0_0_0_1_0_0
  - I-ALU = 1_10_0_0_0_1_0_0
  - load = 1_00_0_1_0_1_1_0
  - store = 1_00_0_0_1_0_0_0
  - branch = 0_01_1_0_0_0_0_0
  - jal/jalr = 1_00_0_0_0_1_0_1
  - lui/auipc = 1_00_0_0_0_1_0_0
  - unknown opcode = all zero (NOP)
- Load-use hazard:
  - Condition: o_stall = i_ex_mem_read & i_ex_rd!=0 & (i_ex_rd==rs1 | (i_ex_rd==rs2 & opcode uses rs2)).
  - Opcodes that use rs2: R, S, B.
  - While o_stall=1: o_control_bits=0 and o_EOF_flag=0 (bubble). Read data and immediate still pass through.
- Halt FSM:
  - RUN: when i_EOF_flag & !o_stall & advance, go to DRAIN and load counter = DRAIN_CYCLES-1.
  - DRAIN: on each advance, decrement the counter. At 0, go to HALTED.
  - HALTED: o_halted=1; o_stall=1; o_control_bits=0. The state persists until reset.
  - Write-back is still accepted in DRAIN and HALTED.
  - Reset mid-drain returns the FSM to RUN.
- Simultaneous write-back to rs and a load-use hazard on the same rs: the stall has priority. Bypass data still appears on o_read_data.

Optional Feature:
ID_STAGE_DBG_PORT_EN:
- Defined: adds ports i_dbg_reg_addr (5 bits, in) and o_dbg_reg_data (32 bits, out). This is a combinational read of any register for the debug unit, without bypass. Reading address 0 returns 0.
- Undefined: these ports and their logic are absent.

Decomposition:
- Shared package/include file holds:
  - opcode localparams
  - control-bit offsets and per-class control words
  - pipeline-mode codes CONT_MODE=2'b01 and STEP_MODE=2'b11
  - halt FSM state encodings
- One sub-module, register_file, covering the 32x32 storage, x0 rule, bypass and optional debug read port. Decode, hazard logic and FSM stay in id_stage.

Test Plan:
- Write-back then read: mode=01, WB x5=0xDEADBEEF, then addi x6,x5,-1 (0xFFF28313) -> o_read_data1=0xDEADBEEF, o_imm_gen=0xFFFFFFFFFFFFFFFF, o_control_bits=9'b110000100.
- Same-cycle bypass: WB x7=0x12 while decoding add x8,x7,x7 -> both read data = 0x12. WB to x0 with 0x55 -> x0 still reads 0.
- Load-use: i_ex_mem_read=1, i_ex_rd=3, decode add x4,x3,x1 -> o_stall=1, o_control_bits=0. Same with sw x3,0(x9) (rs2=x3) -> stall. With addi x4,x9,1 -> no stall.
- Branch immediate: beq with imm=-8 (0xFE000CE3) -> o_imm_gen=0xFFFFFFFFFFFFFFF8, o_control_bits=9'b001100000.
- Stepwise gating: mode=11, i_execute_instruct=0, WB x2=0x77 -> x2 unchanged. Pulse the strobe once -> x2=0x77.
- Halt: EOF in continuous mode -> o_halted rises exactly DRAIN_CYCLES(4) clocks later. Assert reset during DRAIN -> o_halted=0, FSM returns to RUN, all registers read 0.

Source files
------------

// File: rtl/id_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_stage_pkg
// Shared definitions for the instruction-decode stage:
//   - RV32I opcode values
//   - control-word bit offsets and the per-class control words
//   - pipeline-mode codes
//   - halt FSM state encoding
//   - helper: does an opcode read rs2
// ----------------------------------------------------------------------------
package id_stage_pkg;

    // RV32I major opcodes
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Control-word layout
    localparam int NB_CTRL       = 9;
    localparam int CB_ALUSRC     = 8;
    localparam int CB_ALUOP_LSB  = 6;  // ALUOp occupies [7:6]
    localparam int CB_BRANCH     = 5;
    localparam int CB_MEMREAD    = 4;
    localparam int CB_MEMWRITE   = 3;
    localparam int CB_REGWRITE   = 2;
    localparam int CB_MEMTOREG   = 1;
    localparam int CB_JUMP       = 0;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [NB_CTRL-1:0] CTRL_NOP = '0;
    localparam logic [NB_CTRL-1:0] CTRL_R =
        (NB_CTRL'(ALUOP_FUNCT) << CB_ALUOP_LSB) | (NB_CTRL'(1) << CB_REGWRITE);
    localparam logic [NB_CTRL-1:0] CTRL_IALU =
        (NB_CTRL'(1) << CB_ALUSRC) | (NB_CTRL'(ALUOP_FUNCT) << CB_ALUOP_LSB) |
        (NB_CTRL'(1) << CB_REGWRITE);
    localparam logic [NB_CTRL-1:0] CTRL_LOAD =
        (NB_CTRL'(1) << CB_ALUSRC) | (NB_CTRL'(ALUOP_ADD) << CB_ALUOP_LSB) |
        (NB_CTRL'(1) << CB_MEMREAD) | (NB_CTRL'(1) << CB_REGWRITE) |
        (NB_CTRL'(1) << CB_MEMTOREG);
    localparam logic [NB_CTRL-1:0] CTRL_STORE =
        (NB_CTRL'(1) << CB_ALUSRC) | (NB_CTRL'(1) << CB_MEMWRITE);
    localparam logic [NB_CTRL-1:0] CTRL_BRANCH =
        (NB_CTRL'(ALUOP_BRANCH) << CB_ALUOP_LSB) | (NB_CTRL'(1) << CB_BRANCH);
    localparam logic [NB_CTRL-1:0] CTRL_JUMP =
        (NB_CTRL'(1) << CB_ALUSRC) | (NB_CTRL'(1) << CB_REGWRITE) |
        (NB_CTRL'(1) << CB_JUMP);
    localparam logic [NB_CTRL-1:0] CTRL_UPPER =
        (NB_CTRL'(1) << CB_ALUSRC) | (NB_CTRL'(1) << CB_REGWRITE);

    // Pipeline modes; any other code leaves the stage idle
    localparam logic [1:0] CONT_MODE = 2'b01;
    localparam logic [1:0] STEP_MODE = 2'b11;

    // Halt FSM
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_t;

    // R, S and B formats are the only ones whose rs2 field is a real operand
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/id_stage_register_file.sv
// ----------------------------------------------------------------------------
// register_file
// 32 x NB_DATA architectural register file for the decode stage.
//   - x0 is hard-wired to zero on every read port
//   - two combinational read ports with write-through bypass from write-back
//   - synchronous write gated by i_advance, async active-high clear
//   - optional debug read port (no bypass) when ID_STAGE_DBG_PORT_EN is defined
//
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_advance              pipeline may update state this cycle
//   i_rs1, i_rs2           read addresses
//   i_wb_reg_write/rd/data write-back port
//   o_rs1_data/o_rs2_data  read data
//   i_dbg_reg_addr         debug read address      (ID_STAGE_DBG_PORT_EN only)
//   o_dbg_reg_data         debug read data         (ID_STAGE_DBG_PORT_EN only)
// ----------------------------------------------------------------------------
module register_file #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_advance,
    input  logic [NB_ADDR-1:0] i_rs1,
    input  logic [NB_ADDR-1:0] i_rs2,
    input  logic               i_wb_reg_write,
    input  logic [NB_ADDR-1:0] i_wb_rd,
    input  logic [NB_DATA-1:0] i_wb_data,
    output logic [NB_DATA-1:0] o_rs1_data,
    output logic [NB_DATA-1:0] o_rs2_data
`ifdef ID_STAGE_DBG_PORT_EN
    ,
    input  logic [NB_ADDR-1:0] i_dbg_reg_addr,
    output logic [NB_DATA-1:0] o_dbg_reg_data
`endif
);

    localparam int NUM_REGS = 1 << NB_ADDR;

    logic [NB_DATA-1:0] regs [NUM_REGS];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (i_advance && i_wb_reg_write && (i_wb_rd != '0)) begin
            regs[i_wb_rd] <= i_wb_data;
        end
    end

    // Bypass lets an instruction consume a result being written back in the
    // same cycle without waiting for the array update.
    always_comb begin
        o_rs1_data = regs[i_rs1];
        if (i_rs1 == '0) begin
            o_rs1_data = '0;
        end else if (i_wb_reg_write && (i_wb_rd == i_rs1)) begin
            o_rs1_data = i_wb_data;
        end
    end

    always_comb begin
        o_rs2_data = regs[i_rs2];
        if (i_rs2 == '0) begin
            o_rs2_data = '0;
        end else if (i_wb_reg_write && (i_wb_rd == i_rs2)) begin
            o_rs2_data = i_wb_data;
        end
    end

`ifdef ID_STAGE_DBG_PORT_EN
    // Debug view reflects committed state only
    always_comb begin
        o_dbg_reg_data = regs[i_dbg_reg_addr];
        if (i_dbg_reg_addr == '0) begin
            o_dbg_reg_data = '0;
        end
    end
`endif

endmodule

// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage
// RV32I instruction-decode stage feeding the ID/EX pipeline register.
//   - register file (sub-module register_file) with write-back bypass
//   - 9-bit control word and 64-bit sign-extended immediate decode
//   - load-use hazard detection with bubble insertion
//   - end-of-program drain/halt FSM honouring continuous/stepwise modes
// Optional macro: ID_STAGE_DBG_PORT_EN adds a debug register read port.
//
// Ports:
//   i_clk, i_reset               clock, asynchronous active-high reset
//   i_instruction, i_PC          instruction and its PC from IF/ID
//   i_EOF_flag                   end-of-program marker from IF/ID
//   i_pipeline_mode              01 continuous, 11 stepwise, others idle
//   i_execute_instruct           step strobe (stepwise mode)
//   i_wb_reg_write/rd/data       write-back port
//   i_ex_mem_read, i_ex_rd       instruction currently in EX
//   o_control_bits               [8]ALUSrc [7:6]ALUOp [5]Branch [4]MemRead
//                                [3]MemWrite [2]RegWrite [1]MemtoReg [0]Jump
//   o_PC                         pass-through of i_PC
//   o_read_data1/2               rs1/rs2 values
//   o_imm_gen                    sign-extended immediate
//   o_instruct_30_14_12          {instr[30], instr[14:12]}
//   o_instruct_11_7              rd field
//   o_EOF_flag                   EOF forwarded, 0 while stalled
//   o_stall                      freeze PC and IF/ID
//   o_halted                     pipeline drained after EOF
//   i_dbg_reg_addr/o_dbg_reg_data debug read (ID_STAGE_DBG_PORT_EN only)
// ----------------------------------------------------------------------------
module id_stage
    import id_stage_pkg::*;
#(
    parameter int NB_INSTRUCT  = 32,
    parameter int NB_PC        = 6,
    parameter int NB_REG_ADDR  = 5,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NB_INSTRUCT-1:0] i_instruction,
    input  logic [NB_PC-1:0]       i_PC,
    input  logic                   i_EOF_flag,
    input  logic [1:0]             i_pipeline_mode,
    input  logic                   i_execute_instruct,
    input  logic                   i_wb_reg_write,
    input  logic [NB_REG_ADDR-1:0] i_wb_rd,
    input  logic [NB_INSTRUCT-1:0] i_wb_data,
    input  logic                   i_ex_mem_read,
    input  logic [NB_REG_ADDR-1:0] i_ex_rd,
    output logic [8:0]             o_control_bits,
    output logic [NB_PC-1:0]       o_PC,
    output logic [NB_INSTRUCT-1:0] o_read_data1,
    output logic [NB_INSTRUCT-1:0] o_read_data2,
    output logic [63:0]            o_imm_gen,
    output logic [3:0]             o_instruct_30_14_12,
    output logic [4:0]             o_instruct_11_7,
    output logic                   o_EOF_flag,
    output logic                   o_stall,
    output logic                   o_halted
`ifdef ID_STAGE_DBG_PORT_EN
    ,
    input  logic [NB_REG_ADDR-1:0] i_dbg_reg_addr,
    output logic [NB_INSTRUCT-1:0] o_dbg_reg_data
`endif
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    logic [6:0]             opcode;
    logic [NB_REG_ADDR-1:0] rs1;
    logic [NB_REG_ADDR-1:0] rs2;
    logic                   advance;
    logic                   hazard;
    logic                   halted;
    logic [NB_CTRL-1:0]     ctrl_dec;

    halt_state_t            state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;

    assign opcode = i_instruction[6:0];
    assign rs1    = i_instruction[19:15];
    assign rs2    = i_instruction[24:20];

    // Stepwise mode advances only on the step strobe; idle codes freeze state
    assign advance = (i_pipeline_mode == CONT_MODE) ||
                     ((i_pipeline_mode == STEP_MODE) && i_execute_instruct);

    register_file #(
        .NB_DATA (NB_INSTRUCT),
        .NB_ADDR (NB_REG_ADDR)
    ) u_register_file (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_advance      (advance),
        .i_rs1          (rs1),
        .i_rs2          (rs2),
        .i_wb_reg_write (i_wb_reg_write),
        .i_wb_rd        (i_wb_rd),
        .i_wb_data      (i_wb_data),
        .o_rs1_data     (o_read_data1),
        .o_rs2_data     (o_read_data2)
`ifdef ID_STAGE_DBG_PORT_EN
        ,
        .i_dbg_reg_addr (i_dbg_reg_addr),
        .o_dbg_reg_data (o_dbg_reg_data)
`endif
    );

    // Immediate generation: each format assembled into a signed field of its
    // natural width, then sign-extended by the size cast.
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;
    logic signed [63:0] imm_ext;

    assign imm_i = $signed(i_instruction[31:20]);
    assign imm_s = $signed({i_instruction[31:25], i_instruction[11:7]});
    assign imm_b = $signed({i_instruction[31], i_instruction[7],
                            i_instruction[30:25], i_instruction[11:8], 1'b0});
    assign imm_u = $signed({i_instruction[31:12], 12'b0});
    assign imm_j = $signed({i_instruction[31], i_instruction[19:12],
                            i_instruction[20], i_instruction[30:21], 1'b0});

    always_comb begin
        imm_ext = '0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: imm_ext = 64'(imm_i);
            OP_STORE:                 imm_ext = 64'(imm_s);
            OP_BRANCH:                imm_ext = 64'(imm_b);
            OP_LUI, OP_AUIPC:         imm_ext = 64'(imm_u);
            OP_JAL:                   imm_ext = 64'(imm_j);
            default:                  imm_ext = '0;
        endcase
    end

    assign o_imm_gen = imm_ext;

    always_comb begin
        ctrl_dec = CTRL_NOP;
        case (opcode)
            OP_RTYPE:         ctrl_dec = CTRL_R;
            OP_IMM:           ctrl_dec = CTRL_IALU;
            OP_LOAD:          ctrl_dec = CTRL_LOAD;
            OP_STORE:         ctrl_dec = CTRL_STORE;
            OP_BRANCH:        ctrl_dec = CTRL_BRANCH;
            OP_JAL, OP_JALR:  ctrl_dec = CTRL_JUMP;
            OP_LUI, OP_AUIPC: ctrl_dec = CTRL_UPPER;
            default:          ctrl_dec = CTRL_NOP;
        endcase
    end

    // Load-use: the loaded value is not available until after MEM, so a
    // dependent instruction must wait one cycle. rs1 is compared for every
    // opcode; rs2 only where the format actually reads it.
    assign hazard = i_ex_mem_read && (i_ex_rd != '0) &&
                    ((i_ex_rd == rs1) || ((i_ex_rd == rs2) && uses_rs2(opcode)));

    assign halted   = (state == ST_HALTED);
    assign o_halted = halted;
    assign o_stall  = hazard || halted;

    // A bubble suppresses all side effects, including the EOF marker, so the
    // marker is re-presented once the stalled instruction is accepted.
    assign o_control_bits = o_stall ? CTRL_NOP : ctrl_dec;
    assign o_EOF_flag     = i_EOF_flag && !o_stall;

    assign o_PC                = i_PC;
    assign o_instruct_30_14_12 = {i_instruction[30], i_instruction[14:12]};
    assign o_instruct_11_7     = i_instruction[11:7];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else if (advance) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Counter loads DRAIN_CYCLES-1 on entry and HALTED is reached on the
    // advance after it hits zero: DRAIN_CYCLES advances after EOF is taken.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (i_EOF_flag && !hazard) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (cnt == '0) begin
                    state_nxt = ST_HALTED;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_id_stage.sv
// ----------------------------------------------------------------------------
// tb_id_stage
// Directed-vector bench for id_stage. Stimulus pushes expected values into a
// scoreboard queue; a monitor on the falling clock edge pops and compares.
// ----------------------------------------------------------------------------
module tb_id_stage;

    localparam int F_RD1   = 0;
    localparam int F_RD2   = 1;
    localparam int F_IMM   = 2;
    localparam int F_CTRL  = 3;
    localparam int F_STALL = 4;
    localparam int F_HALT  = 5;
    localparam int F_EOF   = 6;
    localparam int F_PC    = 7;
    localparam int F_RD    = 8;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [5:0]  pc;
    logic        eof;
    logic [1:0]  mode;
    logic        exec;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_mr;
    logic [4:0]  ex_rd;

    logic [8:0]  ctrl;
    logic [5:0]  pc_o;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [63:0] imm;
    logic [3:0]  f30;
    logic [4:0]  rdf;
    logic        eof_o;
    logic        stall;
    logic        halted;
`ifdef ID_STAGE_DBG_PORT_EN
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
`endif

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .i_clk               (clk),
        .i_reset             (rst),
        .i_instruction       (instr),
        .i_PC                (pc),
        .i_EOF_flag          (eof),
        .i_pipeline_mode     (mode),
        .i_execute_instruct  (exec),
        .i_wb_reg_write      (wb_we),
        .i_wb_rd             (wb_rd),
        .i_wb_data           (wb_data),
        .i_ex_mem_read       (ex_mr),
        .i_ex_rd             (ex_rd),
        .o_control_bits      (ctrl),
        .o_PC                (pc_o),
        .o_read_data1        (rd1),
        .o_read_data2        (rd2),
        .o_imm_gen           (imm),
        .o_instruct_30_14_12 (f30),
        .o_instruct_11_7     (rdf),
        .o_EOF_flag          (eof_o),
        .o_stall             (stall),
        .o_halted            (halted)
`ifdef ID_STAGE_DBG_PORT_EN
        ,
        .i_dbg_reg_addr      (dbg_addr),
        .o_dbg_reg_data      (dbg_data)
`endif
    );

    function automatic logic [63:0] actual_of(input int sel);
        case (sel)
            F_RD1:   return {32'b0, rd1};
            F_RD2:   return {32'b0, rd2};
            F_IMM:   return imm;
            F_CTRL:  return {55'b0, ctrl};
            F_STALL: return {63'b0, stall};
            F_HALT:  return {63'b0, halted};
            F_EOF:   return {63'b0, eof_o};
            F_PC:    return {58'b0, pc_o};
            F_RD:    return {59'b0, rdf};
            default: return '1;
        endcase
    endfunction

    // Monitor: outputs are compared mid-cycle, away from the active edge
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [63:0] act;
            e   = sb.pop_front();
            act = actual_of(e.sel);
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %0h, expected %0h", e.name, act, e.val);
            end
        end
    end

    task automatic exp_v(input string name, input int sel, input logic [63:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; mode = 2'b01; exec = 1'b0; instr = NOP; pc = '0; eof = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0; ex_mr = 1'b0; ex_rd = '0;

        // Reset state
        tick(); tick();
        instr = 32'hFFF2_8313;
        exp_v("rst_halted", F_HALT, 64'd0);
        exp_v("rst_x5", F_RD1, 64'd0);
        exp_v("rst_stall", F_STALL, 64'd0);
        settle();
        tick(); rst = 1'b0;

        // Write-back then read: addi x6,x5,-1
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF; instr = NOP;
        tick(); wb_we = 1'b0; instr = 32'hFFF2_8313; pc = 6'h2A;
        exp_v("wb_read_x5", F_RD1, 64'hDEAD_BEEF);
        exp_v("addi_imm", F_IMM, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_v("addi_ctrl", F_CTRL, 64'b110000100);
        exp_v("pc_pass", F_PC, 64'h2A);
        exp_v("rd_field", F_RD, 64'd6);
        settle();
        checks++;
        if (rd1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL direct_wb_read_x5: got %0h, expected %0h", rd1, 32'hDEAD_BEEF);
        end

        // Same-cycle bypass: add x8,x7,x7
        tick(); wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h12; instr = 32'h0073_8433;
        exp_v("bypass_rs1", F_RD1, 64'h12);
        exp_v("bypass_rs2", F_RD2, 64'h12);
        exp_v("add_ctrl", F_CTRL, 64'b010000100);
        settle();
        // Write to x0 while reading x0: add x8,x0,x0
        tick(); wb_rd = 5'd0; wb_data = 32'h55; instr = 32'h0000_0433;
        exp_v("x0_bypass_rs1", F_RD1, 64'd0);
        exp_v("x0_bypass_rs2", F_RD2, 64'd0);
        settle();
        // add x8,x7,x0 after both writes committed
        tick(); wb_we = 1'b0; instr = 32'h0003_8433;
        exp_v("x7_stored", F_RD1, 64'h12);
        exp_v("x0_stored", F_RD2, 64'd0);
        settle();

        // Load-use hazards, with EOF held during the first bubble
        tick(); ex_mr = 1'b1; ex_rd = 5'd3; instr = 32'h0011_8233; eof = 1'b1;
        exp_v("lu_rs1_stall", F_STALL, 64'd1);
        exp_v("lu_rs1_ctrl", F_CTRL, 64'd0);
        exp_v("lu_eof_masked", F_EOF, 64'd0);
        settle();
        tick(); eof = 1'b0; instr = 32'h0034_A023;
        exp_v("lu_sw_rs2_stall", F_STALL, 64'd1);
        exp_v("lu_sw_ctrl", F_CTRL, 64'd0);
        settle();
        tick(); instr = 32'h0014_8213;
        exp_v("lu_none_stall", F_STALL, 64'd0);
        exp_v("lu_none_ctrl", F_CTRL, 64'b110000100);
        exp_v("lu_none_imm", F_IMM, 64'd1);
        settle();
        // Hazard and write-back on the same register: stall wins, data bypassed
        tick(); instr = 32'h0011_8233; wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hABC;
        exp_v("lu_wb_stall", F_STALL, 64'd1);
        exp_v("lu_wb_ctrl", F_CTRL, 64'd0);
        exp_v("lu_wb_data", F_RD1, 64'hABC);
        settle();
        // Load into x0 never stalls: add x4,x0,x1
        tick(); wb_we = 1'b0; ex_rd = 5'd0; instr = 32'h0010_0233;
        exp_v("lu_x0_stall", F_STALL, 64'd0);
        exp_v("lu_x0_ctrl", F_CTRL, 64'b010000100);
        settle();

        // Immediate / control decode
        tick(); ex_mr = 1'b0; instr = 32'hFE00_0CE3;
        exp_v("beq_imm", F_IMM, 64'hFFFF_FFFF_FFFF_FFF8);
        exp_v("beq_ctrl", F_CTRL, 64'b001100000);
        settle();
        checks++;
        if (imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin
            errors++;
            $display("FAIL direct_beq_imm: got %0h, expected %0h", imm, 64'hFFFF_FFFF_FFFF_FFF8);
        end
        tick(); instr = 32'h8000_00B7;
        exp_v("lui_imm", F_IMM, 64'hFFFF_FFFF_8000_0000);
        exp_v("lui_ctrl", F_CTRL, 64'b100000100);
        settle();
        tick(); instr = 32'hFFDF_F0EF;
        exp_v("jal_imm", F_IMM, 64'hFFFF_FFFF_FFFF_FFFC);
        exp_v("jal_ctrl", F_CTRL, 64'b100000101);
        settle();
        tick(); instr = 32'hFE34_AE23;
        exp_v("sw_imm", F_IMM, 64'hFFFF_FFFF_FFFF_FFFC);
        exp_v("sw_ctrl", F_CTRL, 64'b100001000);
        settle();
        tick(); instr = 32'h0081_2083;
        exp_v("lw_imm", F_IMM, 64'd8);
        exp_v("lw_ctrl", F_CTRL, 64'b100010110);
        settle();
        tick(); instr = 32'hFFFF_FFFF;
        exp_v("unk_imm", F_IMM, 64'd0);
        exp_v("unk_ctrl", F_CTRL, 64'd0);
        settle();

        // Stepwise gating
        tick(); mode = 2'b11; exec = 1'b0; wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h77; instr = NOP;
        tick(); wb_we = 1'b0; instr = 32'h0001_0013;
        exp_v("step_no_strobe", F_RD1, 64'd0);
        settle();
        tick(); wb_we = 1'b1; exec = 1'b1;
        tick(); wb_we = 1'b0; exec = 1'b0;
        exp_v("step_strobe", F_RD1, 64'h77);
        settle();

        // Halt after EOF in continuous mode
        tick(); mode = 2'b01; eof = 1'b1; instr = NOP;
        exp_v("eof_pass", F_EOF, 64'd1);
        exp_v("pre_eof_halt", F_HALT, 64'd0);
        settle();
        tick(); eof = 1'b0;
        exp_v("drain_c0", F_HALT, 64'd0);
        settle();
        for (int i = 1; i < 4; i++) begin
            tick();
            exp_v($sformatf("drain_c%0d", i), F_HALT, 64'd0);
            settle();
        end
        tick(); instr = 32'h0014_8213;
        exp_v("halted_c4", F_HALT, 64'd1);
        exp_v("halted_stall", F_STALL, 64'd1);
        exp_v("halted_ctrl", F_CTRL, 64'd0);
        settle();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL direct_halted_c4: got %0h, expected %0h", halted, 1'b1);
        end
        // Write-back still accepted while halted
        tick(); wb_we = 1'b1; wb_rd = 5'd11; wb_data = 32'h5A;
        tick(); wb_we = 1'b0; instr = 32'h0005_8013;
        exp_v("halted_wb", F_RD1, 64'h5A);
        exp_v("halted_persist", F_HALT, 64'd1);
        settle();

        // Reset from HALTED clears registers
        tick(); rst = 1'b1; instr = 32'h0002_8013;
        exp_v("rst2_x5", F_RD1, 64'd0);
        exp_v("rst2_halt", F_HALT, 64'd0);
        exp_v("rst2_stall", F_STALL, 64'd0);
        settle();
        tick(); rst = 1'b0;

        // Reset in the middle of DRAIN
        wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'h99; eof = 1'b1;
        tick(); wb_we = 1'b0; eof = 1'b0;
        tick();
        tick(); rst = 1'b1; instr = 32'h0005_0013;
        exp_v("middrain_x10", F_RD1, 64'd0);
        exp_v("middrain_halt", F_HALT, 64'd0);
        settle();
        tick(); rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        exp_v("after_rst_run", F_HALT, 64'd0);
        exp_v("after_rst_stall", F_STALL, 64'd0);
        settle();
        // Fresh EOF must take the full drain again
        tick(); eof = 1'b1;
        tick(); eof = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        exp_v("redrain_c3", F_HALT, 64'd0);
        settle();
        tick();
        exp_v("redrain_c4", F_HALT, 64'd1);
        settle();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL direct_redrain_c4: got %0h, expected %0h", halted, 1'b1);
        end

        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
